// File: rtl/mips_mc_control.sv
// mips_mc_control
//   Multi-cycle MIPS control unit. It contains the main sequencing FSM
//   (FETCH/DECODE/execute states) and the ALU decoder that drives the 3-bit
//   ALUControl code to the ALU.
//
//   Optional feature macro: MIPS_MC_MEM_WAIT_EN
//     When defined, FETCH, MEMRD and MEMWR hold until mem_ready=1. IRWrite and
//     PCWrite are gated to the ready cycle. When undefined, mem_ready is ignored
//     and every memory access completes in one cycle.
//
//   Ports
//     clk, rst_n      clock (rising edge), synchronous active-low reset
//     opcode, funct   instr[31:26] / instr[5:0] from the IR
//     zero            ALU result == 0, used for beq
//     mem_ready       memory handshake (wait-state build only)
//     ALUControl      000 AND, 001 OR, 010 ADD, 110 SUB, 011 NOT A, 100 XOR, 111 SLT
//     ALUSrcA/B, ImmZext, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//     PCSrc, PCEn     datapath selects and enables
//     illegal_op      one-cycle pulse in DECODE on an unsupported opcode/funct
//     state_dbg       current state code
module mips_mc_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         ALUControl,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ImmZext,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_MEMADR = STATE_W'(3),
    S_MEMRD  = STATE_W'(4),
    S_MEMWB  = STATE_W'(5),
    S_MEMWR  = STATE_W'(6),
    S_EXEC   = STATE_W'(7),
    S_ALUWB  = STATE_W'(8),
    S_BRANCH = STATE_W'(9),
    S_IEXEC  = STATE_W'(10),
    S_IWB    = STATE_W'(11),
    S_JUMP   = STATE_W'(12)
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t r_state, w_next;
  logic   r_is_sw;      // lw/sw captured in DECODE so MEMADR needs no opcode
  logic   w_ready;
  logic   w_pcwrite, w_branch;
  logic [2:0] w_funct_alu, w_imm_alu;
  logic   w_funct_ok, w_imm_zext;

`ifdef MIPS_MC_MEM_WAIT_EN
  assign w_ready = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_ready = 1'b1;
`endif

  // R-type funct decode; w_funct_ok lets DECODE reject bad functs early
  always_comb begin
    w_funct_alu = ALU_ADD;
    w_funct_ok  = 1'b1;
    case (funct)
      6'b100000: w_funct_alu = ALU_ADD;
      6'b100010: w_funct_alu = ALU_SUB;
      6'b100100: w_funct_alu = ALU_AND;
      6'b100101: w_funct_alu = ALU_OR;
      6'b100110: w_funct_alu = ALU_XOR;
      6'b101010: w_funct_alu = ALU_SLT;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  // I-type decode; logical immediates are zero-extended
  always_comb begin
    w_imm_alu  = ALU_ADD;
    w_imm_zext = 1'b0;
    case (opcode)
      OP_ANDI: begin w_imm_alu = ALU_AND; w_imm_zext = 1'b1; end
      OP_ORI:  begin w_imm_alu = ALU_OR;  w_imm_zext = 1'b1; end
      OP_XORI: begin w_imm_alu = ALU_XOR; w_imm_zext = 1'b1; end
      OP_SLTI: w_imm_alu = ALU_SLT;
      default: w_imm_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RESET;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_is_sw <= (opcode == OP_SW);
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmZext    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        IRWrite   = w_ready;  // one IR load / PC increment per fetch
        w_pcwrite = w_ready;
        w_next    = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;      // PC + (imm<<2) into ALUOut for beq
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R: begin
            if (w_funct_ok) w_next = S_EXEC;
            else            illegal_op = 1'b1;
          end
          OP_BEQ: w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: w_next = S_IEXEC;
          OP_J:   w_next = S_JUMP;
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = r_is_sw ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;      // held through the stall, drops after ready
        w_next   = w_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        w_branch   = 1'b1;
        PCSrc      = 2'b01;
      end
      S_IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = w_imm_alu;
        ImmZext    = w_imm_zext;
        w_next     = S_IWB;
      end
      S_IWB: begin
        ALUControl = w_imm_alu;
        ImmZext    = w_imm_zext;
        RegWrite   = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;   // unused codes recover
    endcase
  end

  assign PCEn      = w_pcwrite | (w_branch & zero);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic [2:0] ALUControl;
  logic       ALUSrcA, ImmZext, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn, illegal_op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] state_dbg;
  int n_cmp = 0, n_fail = 0;

  mips_mc_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmZext(ImmZext), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCSrc(PCSrc), .PCEn(PCEn),
    .illegal_op(illegal_op), .state_dbg(state_dbg));

  always #5 clk = ~clk;

  // {ALUControl,ALUSrcA,ALUSrcB,ImmZext,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,PCSrc,PCEn,illegal_op}
  logic [16:0] ctl;
  assign ctl = {ALUControl, ALUSrcA, ALUSrcB, ImmZext, IorD, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, PCSrc, PCEn, illegal_op};

  localparam logic [16:0] E_RESET  = 17'b010_0_00_0_0_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_FETCH  = 17'b010_0_01_0_0_0_1_0_0_0_00_1_0;
  localparam logic [16:0] E_FSTALL = 17'b010_0_01_0_0_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_DECODE = 17'b010_0_11_0_0_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_DEC_IL = 17'b010_0_11_0_0_0_0_0_0_0_00_0_1;
  localparam logic [16:0] E_MEMADR = 17'b010_1_10_0_0_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_MEMRD  = 17'b010_0_00_0_1_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_MEMWB  = 17'b010_0_00_0_0_0_0_0_1_1_00_0_0;
  localparam logic [16:0] E_MEMWR  = 17'b010_0_00_0_1_1_0_0_0_0_00_0_0;
  localparam logic [16:0] E_EXSUB  = 17'b110_1_00_0_0_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_ALUWB  = 17'b010_0_00_0_0_0_0_1_0_1_00_0_0;
  localparam logic [16:0] E_BR_T   = 17'b110_1_00_0_0_0_0_0_0_0_01_1_0;
  localparam logic [16:0] E_BR_NT  = 17'b110_1_00_0_0_0_0_0_0_0_01_0_0;
  localparam logic [16:0] E_IXORI  = 17'b001_1_10_1_0_0_0_0_0_0_00_0_0;
  localparam logic [16:0] E_IWBORI = 17'b001_0_00_1_0_0_0_0_0_1_00_0_0;
  localparam logic [16:0] E_JUMP   = 17'b010_0_00_0_0_0_0_0_0_0_10_1_0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // rst_n low for 3 clocks, then FETCH and DECODE (opcode = j for the next test)
  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state_dbg !== 4'd0 || ctl !== E_RESET) begin
        $display("FAIL reset[%0d] state=%0d ctl=%h expected state=0 ctl=%h", i, state_dbg, ctl, E_RESET); n_fail++;
      end
      n_cmp++;
    end
    rst_n = 1'b1;
    tick();
    if (state_dbg !== 4'd1 || ctl !== E_FETCH) begin
      $display("FAIL reset_fetch state=%0d ctl=%h expected state=1 ctl=%h", state_dbg, ctl, E_FETCH); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd2 || ctl !== E_DECODE) begin
      $display("FAIL reset_decode state=%0d ctl=%h expected state=2 ctl=%h", state_dbg, ctl, E_DECODE); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_jump();
    tick();
    if (state_dbg !== 4'd12 || ctl !== E_JUMP) begin
      $display("FAIL jump state=%0d ctl=%h expected state=12 ctl=%h", state_dbg, ctl, E_JUMP); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1 || ctl !== E_FETCH) begin
      $display("FAIL jump_fetch state=%0d ctl=%h expected state=1 ctl=%h", state_dbg, ctl, E_FETCH); n_fail++;
    end
    n_cmp++;
  endtask

  // sub: FETCH -> DECODE -> EXEC -> ALUWB -> FETCH (4 cycles)
  task automatic test_rtype();
    logic [5:0] fn [5] = '{6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    logic [2:0] ac [5] = '{3'b010, 3'b000, 3'b001, 3'b100, 3'b111};
    opcode = 6'b000000; funct = 6'b100010;
    tick();
    if (state_dbg !== 4'd2 || ctl !== E_DECODE) begin
      $display("FAIL sub_decode state=%0d ctl=%h expected state=2 ctl=%h", state_dbg, ctl, E_DECODE); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd7 || ctl !== E_EXSUB) begin
      $display("FAIL sub_exec state=%0d ctl=%h expected state=7 ctl=%h", state_dbg, ctl, E_EXSUB); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd8 || ctl !== E_ALUWB) begin
      $display("FAIL sub_aluwb state=%0d ctl=%h expected state=8 ctl=%h", state_dbg, ctl, E_ALUWB); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1) begin
      $display("FAIL sub_latency state=%0d expected 1", state_dbg); n_fail++;
    end
    n_cmp++;
    for (int i = 0; i < 5; i++) begin
      funct = fn[i];
      tick(); tick();
      if (state_dbg !== 4'd7 || ALUControl !== ac[i] || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
        $display("FAIL funct_%b state=%0d alu=%b srcA=%b srcB=%b expected 7 %b 1 00", fn[i], state_dbg, ALUControl, ALUSrcA, ALUSrcB, ac[i]); n_fail++;
      end
      n_cmp++;
      tick(); tick();
    end
  endtask

  task automatic test_beq();
    opcode = 6'b000100; zero = 1'b1;
    tick(); tick();
    if (state_dbg !== 4'd9 || ctl !== E_BR_T) begin
      $display("FAIL beq_taken state=%0d ctl=%h expected state=9 ctl=%h", state_dbg, ctl, E_BR_T); n_fail++;
    end
    n_cmp++;
    tick();
    zero = 1'b0; #1;
    if (state_dbg !== 4'd1 || ctl !== E_FETCH) begin
      $display("FAIL beq_latency state=%0d ctl=%h expected state=1 ctl=%h", state_dbg, ctl, E_FETCH); n_fail++;
    end
    n_cmp++;
    tick(); tick();
    if (state_dbg !== 4'd9 || ctl !== E_BR_NT) begin
      $display("FAIL beq_not_taken state=%0d ctl=%h expected state=9 ctl=%h", state_dbg, ctl, E_BR_NT); n_fail++;
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_lw_sw();
    opcode = 6'b100011;
    tick(); tick();
    if (state_dbg !== 4'd3 || ctl !== E_MEMADR) begin
      $display("FAIL lw_memadr state=%0d ctl=%h expected state=3 ctl=%h", state_dbg, ctl, E_MEMADR); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd4 || ctl !== E_MEMRD) begin
      $display("FAIL lw_memrd state=%0d ctl=%h expected state=4 ctl=%h", state_dbg, ctl, E_MEMRD); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd5 || ctl !== E_MEMWB) begin
      $display("FAIL lw_memwb state=%0d ctl=%h expected state=5 ctl=%h", state_dbg, ctl, E_MEMWB); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1) begin
      $display("FAIL lw_latency state=%0d expected 1", state_dbg); n_fail++;
    end
    n_cmp++;
    opcode = 6'b101011;
    tick(); tick(); tick();
    if (state_dbg !== 4'd6 || ctl !== E_MEMWR) begin
      $display("FAIL sw_memwr state=%0d ctl=%h expected state=6 ctl=%h", state_dbg, ctl, E_MEMWR); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1) begin
      $display("FAIL sw_latency state=%0d expected 1", state_dbg); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_itype();
    logic [5:0] op [4] = '{6'b001000, 6'b001100, 6'b001110, 6'b001010};
    logic [3:0] ez [4] = '{4'b010_0, 4'b000_1, 4'b100_1, 4'b111_0};
    opcode = 6'b001101;
    tick(); tick();
    if (state_dbg !== 4'd10 || ctl !== E_IXORI) begin
      $display("FAIL ori_iexec state=%0d ctl=%h expected state=10 ctl=%h", state_dbg, ctl, E_IXORI); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd11 || ctl !== E_IWBORI) begin
      $display("FAIL ori_iwb state=%0d ctl=%h expected state=11 ctl=%h", state_dbg, ctl, E_IWBORI); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1) begin
      $display("FAIL ori_latency state=%0d expected 1", state_dbg); n_fail++;
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      opcode = op[i];
      tick(); tick();
      if (state_dbg !== 4'd10 || {ALUControl, ImmZext} !== ez[i]) begin
        $display("FAIL imm_%b state=%0d alu_zext=%b expected 10 %b", op[i], state_dbg, {ALUControl, ImmZext}, ez[i]); n_fail++;
      end
      n_cmp++;
      tick(); tick();
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    tick();
    if (state_dbg !== 4'd2 || ctl !== E_DEC_IL) begin
      $display("FAIL illegal_op state=%0d ctl=%h expected state=2 ctl=%h", state_dbg, ctl, E_DEC_IL); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1 || ctl !== E_FETCH) begin
      $display("FAIL illegal_next state=%0d ctl=%h expected state=1 ctl=%h", state_dbg, ctl, E_FETCH); n_fail++;
    end
    n_cmp++;
    opcode = 6'b000000; funct = 6'b000111;
    tick();
    if (state_dbg !== 4'd2 || ctl !== E_DEC_IL) begin
      $display("FAIL illegal_funct state=%0d ctl=%h expected state=2 ctl=%h", state_dbg, ctl, E_DEC_IL); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1 || RegWrite !== 1'b0) begin
      $display("FAIL illegal_funct_next state=%0d regwrite=%b expected 1 0", state_dbg, RegWrite); n_fail++;
    end
    n_cmp++;
  endtask

`ifdef MIPS_MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    int pulses = 0;
    opcode = 6'b101011;
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      if (state_dbg !== 4'd1 || ctl !== E_FSTALL) begin
        $display("FAIL fetch_stall[%0d] state=%0d ctl=%h expected state=1 ctl=%h", i, state_dbg, ctl, E_FSTALL); n_fail++;
      end
      n_cmp++;
      tick();
    end
    mem_ready = 1'b1; #1;
    if (PCEn) pulses++;
    tick();
    if (PCEn) pulses++;
    if (pulses !== 1 || state_dbg !== 4'd2) begin
      $display("FAIL fetch_release pcen_pulses=%0d state=%0d expected 1 2", pulses, state_dbg); n_fail++;
    end
    n_cmp++;
    mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    if (state_dbg !== 4'd6 || MemWrite !== 1'b1) begin
      $display("FAIL memwr_stall state=%0d memwrite=%b expected 6 1", state_dbg, MemWrite); n_fail++;
    end
    n_cmp++;
    rst_n = 1'b0;
    tick();
    if (state_dbg !== 4'd0 || MemWrite !== 1'b0) begin
      $display("FAIL memwr_reset state=%0d memwrite=%b expected 0 0", state_dbg, MemWrite); n_fail++;
    end
    n_cmp++;
    rst_n = 1'b1; mem_ready = 1'b1;
    tick();
  endtask
`else
  // mem_ready is ignored: sw still completes in 4 cycles with it held low
  task automatic test_no_wait();
    opcode = 6'b101011; mem_ready = 1'b0; #1;
    if (ctl !== E_FETCH) begin
      $display("FAIL nowait_fetch ctl=%h expected %h", ctl, E_FETCH); n_fail++;
    end
    n_cmp++;
    tick(); tick(); tick();
    if (state_dbg !== 4'd6 || ctl !== E_MEMWR) begin
      $display("FAIL nowait_memwr state=%0d ctl=%h expected state=6 ctl=%h", state_dbg, ctl, E_MEMWR); n_fail++;
    end
    n_cmp++;
    tick();
    if (state_dbg !== 4'd1) begin
      $display("FAIL nowait_latency state=%0d expected 1", state_dbg); n_fail++;
    end
    n_cmp++;
    mem_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_jump();
    test_rtype();
    test_beq();
    test_lw_sw();
    test_itype();
    test_illegal();
`ifdef MIPS_MC_MEM_WAIT_EN
    test_mem_wait();
`else
    test_no_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
